// File: rtl/uart_receiver_param.sv
// Parametrised UART receiver: synchronises rx, deserialises start/data/parity/stop,
// and hands each frame to the controller through a level interrupt with ack pulse.
module uart_receiver_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 disable_data_interrupt,
  output logic                 enable_data_interrupt,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam logic [15:0] BIT_END       = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END      = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  LAST_DATA     = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP     = 4'(STOP_BITS - 1);
  localparam logic        PARITY_EXPECT = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] bits, input logic sample);
    return (((^bits) ^ sample) != PARITY_EXPECT);
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  state_t                 state, state_next;
  logic [15:0]            baud_cnt, baud_next;
  logic [3:0]             bit_idx, idx_next;
  logic [DATA_BITS-1:0]   shift_q, shift_next;
  logic                   par_q, par_next;
  logic                   frm_q, frm_next;
  logic                   done;
  logic                   done_frm;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // rx synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{1'b1}};
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  // FSM and frame-assembly registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 4'd0;
      shift_q  <= {DATA_BITS{1'b0}};
      par_q    <= 1'b0;
      frm_q    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= idx_next;
      shift_q  <= shift_next;
      par_q    <= par_next;
      frm_q    <= frm_next;
      busy     <= (state_next != IDLE);
    end
  end

  // Next-state logic; all sampling happens when the baud counter hits its target
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + 16'd1;
    idx_next   = bit_idx;
    shift_next = shift_q;
    par_next   = par_q;
    frm_next   = frm_q;
    done       = 1'b0;
    done_frm   = frm_q;
    case (state)
      IDLE: begin
        baud_next = 16'd0;
        if (rx_prev && !rx_s) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (baud_cnt == HALF_END) begin
          baud_next = 16'd0;
          idx_next  = 4'd0;
          par_next  = 1'b0;
          frm_next  = 1'b0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_END) begin
          baud_next  = 16'd0;
          shift_next = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx == LAST_DATA) begin
            idx_next   = 4'd0;
            state_next = (PARITY_MODE == 0) ? STOP : PARITY;
          end else begin
            idx_next = bit_idx + 4'd1;
          end
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (baud_cnt == BIT_END) begin
          baud_next  = 16'd0;
          par_next   = parity_bad(shift_q, rx_s);
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_END) begin
          baud_next = 16'd0;
          done_frm  = frm_q | ~rx_s;
          frm_next  = done_frm;
          if (bit_idx == LAST_STOP) begin
            done       = 1'b1;
            idx_next   = 4'd0;
            // a low stop bit may be a break; wait for the line to recover
            state_next = done_frm ? BREAK : IDLE;
          end else begin
            idx_next = bit_idx + 4'd1;
          end
        end else begin
          state_next = STOP;
        end
      end
      BREAK: begin
        baud_next = 16'd0;
        if (rx_s) begin
          state_next = IDLE;
        end else begin
          state_next = BREAK;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = 16'd0;
      end
    endcase
  end

  // Delivery registers and controller handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_data_interrupt <= 1'b0;
      data                  <= {DATA_BITS{1'b0}};
      parity_error          <= 1'b0;
      framing_error         <= 1'b0;
      overrun_error         <= 1'b0;
    end else if (done && (!enable_data_interrupt || disable_data_interrupt)) begin
      enable_data_interrupt <= 1'b1;
      data                  <= shift_q;
      parity_error          <= par_q;
      framing_error         <= done_frm;
      overrun_error         <= 1'b0;
    end else if (done) begin
      overrun_error <= 1'b1;
    end else if (enable_data_interrupt && disable_data_interrupt) begin
      enable_data_interrupt <= 1'b0;
      parity_error          <= 1'b0;
      framing_error         <= 1'b0;
      overrun_error         <= 1'b0;
    end else begin
      enable_data_interrupt <= enable_data_interrupt;
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// Self-checking bench for uart_receiver_param: five configurations share one clock,
// frames are built from bit lists and checked against a frame-level reference model.
module tb_uart_receiver_param;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int NDUT = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NDUT-1:0] rx  = '1;
  logic [NDUT-1:0] ack = '0;
  logic [NDUT-1:0] irq, pe, fe, ov, bsy;
  logic [7:0]      d0, d1, d2, d3;
  logic [4:0]      d4;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int rises [NDUT] = '{default: 0};
  int rise_cyc [NDUT] = '{default: 0};
  logic [NDUT-1:0] irq_prev = '0;

  // frame-level reference model
  logic [8:0] m_data [NDUT];
  logic       m_irq [NDUT];
  logic       m_pe [NDUT];
  logic       m_fe [NDUT];
  logic       m_ov [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (irq[k] && !irq_prev[k]) begin
        rises[k]    <= rises[k] + 1;
        rise_cyc[k] <= cyc;
      end
    end
    irq_prev <= irq;
  end

  uart_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_plain (
    .clk(clk), .rst(rst), .rx(rx[0]), .disable_data_interrupt(ack[0]), .enable_data_interrupt(irq[0]),
    .data(d0), .parity_error(pe[0]), .framing_error(fe[0]), .overrun_error(ov[0]), .busy(bsy[0]));
  uart_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_even (
    .clk(clk), .rst(rst), .rx(rx[1]), .disable_data_interrupt(ack[1]), .enable_data_interrupt(irq[1]),
    .data(d1), .parity_error(pe[1]), .framing_error(fe[1]), .overrun_error(ov[1]), .busy(bsy[1]));
  uart_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_odd (
    .clk(clk), .rst(rst), .rx(rx[2]), .disable_data_interrupt(ack[2]), .enable_data_interrupt(irq[2]),
    .data(d2), .parity_error(pe[2]), .framing_error(fe[2]), .overrun_error(ov[2]), .busy(bsy[2]));
  uart_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .SYNC_STAGES(SYNC)) u_stop2 (
    .clk(clk), .rst(rst), .rx(rx[3]), .disable_data_interrupt(ack[3]), .enable_data_interrupt(irq[3]),
    .data(d3), .parity_error(pe[3]), .framing_error(fe[3]), .overrun_error(ov[3]), .busy(bsy[3]));
  uart_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_w5 (
    .clk(clk), .rst(rst), .rx(rx[4]), .disable_data_interrupt(ack[4]), .enable_data_interrupt(irq[4]),
    .data(d4), .parity_error(pe[4]), .framing_error(fe[4]), .overrun_error(ov[4]), .busy(bsy[4]));

  function automatic int db(input int k); return (k == 4) ? 5 : 8; endfunction
  function automatic int pm(input int k); return (k == 1) ? 2 : ((k == 2) ? 1 : 0); endfunction
  function automatic int sb(input int k); return (k == 3) ? 2 : 1; endfunction
  function automatic int nbits(input int k); return db(k) + ((pm(k) != 0) ? 1 : 0) + sb(k); endfunction

  // fall-to-interrupt: sync stages, edge detect, half a bit to the start centre, then every bit after it
  function automatic int irq_cycle(input int k, input int c0);
    return c0 + SYNC + 1 + CPB / 2 + nbits(k) * CPB;
  endfunction

  function automatic logic [8:0] datk(input int k);
    case (k)
      0: return {1'b0, d0};
      1: return {1'b0, d1};
      2: return {1'b0, d2};
      3: return {1'b0, d3};
      default: return {4'b0000, d4};
    endcase
  endfunction

  function automatic logic [12:0] obs(input int k);
    return {irq[k], ov[k], fe[k], pe[k], datk(k)};
  endfunction

  function automatic logic [12:0] expv(input int k);
    return {m_irq[k], m_ov[k], m_fe[k], m_pe[k], m_data[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_data[k] = 9'd0; m_irq[k] = 1'b0; m_pe[k] = 1'b0; m_fe[k] = 1'b0; m_ov[k] = 1'b0;
    end
  endtask

  // a completed frame either loads (no pending frame, or acked on the same clock) or overruns
  task automatic model_frame(input int k, input logic [8:0] v, input int pbit, input logic [1:0] stop_low, input bit ack_same);
    bit p_err, f_err;
    p_err = (pm(k) != 0) && ((($countones(v) + pbit) % 2) != ((pm(k) == 1) ? 1 : 0));
    f_err = (sb(k) == 2) ? (stop_low != 2'b00) : stop_low[0];
    if (!m_irq[k] || ack_same) begin
      m_data[k] = v; m_irq[k] = 1'b1; m_pe[k] = p_err; m_fe[k] = f_err; m_ov[k] = 1'b0;
    end else begin
      m_ov[k] = 1'b1;
    end
  endtask

  task automatic send(input int k, input logic [8:0] v, input int pbit, input logic [1:0] stop_low,
                      input int nsend, output int c0);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < db(k); i++) q.push_back(v[i]);
    if (pm(k) != 0) q.push_back(pbit[0]);
    for (int i = 0; i < sb(k); i++) q.push_back(!stop_low[i]);
    c0 = cyc;
    for (int i = 0; i < q.size() && i < nsend; i++) begin
      rx[k] = q[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic pulse_ack(input int k);
    ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
    if (m_irq[k]) begin
      m_irq[k] = 1'b0; m_pe[k] = 1'b0; m_fe[k] = 1'b0; m_ov[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++;
      if ({bsy[k], obs(k)} !== {1'b0, expv(k)}) begin
        n_fail++;
        $display("FAIL reset k=%0d got busy/irq/ov/fe/pe/data=%b want %b", k, {bsy[k], obs(k)}, {1'b0, expv(k)});
      end
    end
  endtask

  task automatic test_clean();
    int c0;
    int exp_cyc;
    logic [8:0] v;
    send(0, 9'h0AA, 0, 2'b00, 99, c0);
    model_frame(0, 9'h0AA, 0, 2'b00, 1'b0);
    exp_cyc = irq_cycle(0, c0);
    n_cmp++;
    if (rise_cyc[0] < exp_cyc - 1 || rise_cyc[0] > exp_cyc + 1) begin
      n_fail++;
      $display("FAIL clean_latency irq rose at cycle %0d want %0d (+/-1)", rise_cyc[0], exp_cyc);
    end
    n_cmp++;
    if (obs(0) !== expv(0)) begin
      n_fail++;
      $display("FAIL clean_frame got irq/ov/fe/pe/data=%b want %b", obs(0), expv(0));
    end
    pulse_ack(0);
    n_cmp++;
    if (obs(0) !== expv(0)) begin
      n_fail++;
      $display("FAIL clean_ack got irq/ov/fe/pe/data=%b want %b", obs(0), expv(0));
    end
    for (int i = 0; i < 3; i++) begin
      v = 9'($urandom_range(0, 255));
      send(0, v, 0, 2'b00, 99, c0);
      model_frame(0, v, 0, 2'b00, 1'b0);
      n_cmp++;
      if (obs(0) !== expv(0)) begin
        n_fail++;
        $display("FAIL clean_random got irq/ov/fe/pe/data=%b want %b", obs(0), expv(0));
      end
      pulse_ack(0);
    end
  endtask

  task automatic test_parity();
    int c0;
    int pb;
    logic [8:0] v;
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        v  = (i < 2) ? 9'h003 : 9'($urandom_range(0, 255));
        pb = (i < 2) ? i : int'($urandom_range(0, 1));
        send(k, v, pb, 2'b00, 99, c0);
        model_frame(k, v, pb, 2'b00, 1'b0);
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL parity k=%0d v=%h p=%0d got irq/ov/fe/pe/data=%b want %b", k, v, pb, obs(k), expv(k));
        end
        pulse_ack(k);
      end
    end
  endtask

  task automatic test_framing();
    int c0;
    int r0;
    r0 = rises[3];
    send(3, 9'h055, 0, 2'b10, 99, c0);
    model_frame(3, 9'h055, 0, 2'b10, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    n_cmp++;
    if ({bsy[3], rises[3] - r0} !== {1'b1, 32'sd1}) begin
      n_fail++;
      $display("FAIL break_hold busy=%b irqs=%0d want busy=1 irqs=1", bsy[3], rises[3] - r0);
    end
    rx[3] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++;
    if ({bsy[3], rises[3] - r0} !== {1'b0, 32'sd1}) begin
      n_fail++;
      $display("FAIL break_release busy=%b irqs=%0d want busy=0 irqs=1", bsy[3], rises[3] - r0);
    end
    n_cmp++;
    if (obs(3) !== expv(3)) begin
      n_fail++;
      $display("FAIL framing got irq/ov/fe/pe/data=%b want %b", obs(3), expv(3));
    end
    pulse_ack(3);
    n_cmp++;
    if (obs(3) !== expv(3)) begin
      n_fail++;
      $display("FAIL framing_ack got irq/ov/fe/pe/data=%b want %b", obs(3), expv(3));
    end
  endtask

  task automatic test_overrun();
    int c0;
    send(0, 9'h011, 0, 2'b00, 99, c0);
    model_frame(0, 9'h011, 0, 2'b00, 1'b0);
    send(0, 9'h022, 0, 2'b00, 99, c0);
    model_frame(0, 9'h022, 0, 2'b00, 1'b0);
    n_cmp++;
    if (obs(0) !== expv(0)) begin
      n_fail++;
      $display("FAIL overrun got irq/ov/fe/pe/data=%b want %b", obs(0), expv(0));
    end
    pulse_ack(0);
    n_cmp++;
    if (obs(0) !== expv(0)) begin
      n_fail++;
      $display("FAIL overrun_ack got irq/ov/fe/pe/data=%b want %b", obs(0), expv(0));
    end
  endtask

  task automatic test_glitch();
    int c0;
    int r0;
    r0 = rises[0];
    c0 = cyc;
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    while (cyc < c0 + 5) @(negedge clk);
    n_cmp++;
    if (bsy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start busy=%b want 1", bsy[0]);
    end
    while (cyc < c0 + 20) @(negedge clk);
    n_cmp++;
    if ({bsy[0], rises[0] - r0, obs(0)} !== {1'b0, 32'sd0, expv(0)}) begin
      n_fail++;
      $display("FAIL glitch_end busy=%b irqs=%0d state=%b want busy=0 irqs=0 state=%b",
               bsy[0], rises[0] - r0, obs(0), expv(0));
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    logic [8:0] v;
    v = 9'($urandom_range(0, 255));
    send(0, v, 0, 2'b00, 99, c0);
    model_frame(0, v, 0, 2'b00, 1'b0);
    send(0, 9'h05A, 0, 2'b00, 4, c0);
    rst   = 1'b1;
    rx[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({bsy[0], obs(0)} !== {1'b0, expv(0)}) begin
      n_fail++;
      $display("FAIL reset_midframe got busy/irq/ov/fe/pe/data=%b want %b", {bsy[0], obs(0)}, {1'b0, expv(0)});
    end
    repeat (2 * CPB) @(negedge clk);
    send(0, 9'h03C, 0, 2'b00, 99, c0);
    model_frame(0, 9'h03C, 0, 2'b00, 1'b0);
    n_cmp++;
    if (obs(0) !== expv(0)) begin
      n_fail++;
      $display("FAIL after_reset got irq/ov/fe/pe/data=%b want %b", obs(0), expv(0));
    end
    pulse_ack(0);
  endtask

  task automatic test_back_to_back();
    int c0;
    int dummy;
    int f0;
    logic [8:0] vals [3];
    vals[0] = 9'h01F;
    vals[1] = 9'h00A;
    vals[2] = 9'($urandom_range(0, 31));
    c0 = cyc;
    f0 = irq_cycle(4, c0);
    fork
      begin
        for (int j = 0; j < 3; j++) send(4, vals[j], 0, 2'b00, 99, dummy);
      end
      begin
        while (cyc < f0 + 1) @(negedge clk);
        model_frame(4, vals[0], 0, 2'b00, 1'b0);
        n_cmp++;
        if (obs(4) !== expv(4)) begin
          n_fail++;
          $display("FAIL b2b_first got irq/ov/fe/pe/data=%b want %b", obs(4), expv(4));
        end
        for (int j = 1; j < 3; j++) begin
          while (cyc < f0 + j * (1 + nbits(4)) * CPB - 1) @(negedge clk);
          ack[4] = 1'b1;
          @(negedge clk);
          ack[4] = 1'b0;
          model_frame(4, vals[j], 0, 2'b00, 1'b1);
          @(negedge clk);
          n_cmp++;
          if (obs(4) !== expv(4)) begin
            n_fail++;
            $display("FAIL b2b_frame%0d got irq/ov/fe/pe/data=%b want %b", j, obs(4), expv(4));
          end
        end
      end
    join
    pulse_ack(4);
    n_cmp++;
    if (obs(4) !== expv(4)) begin
      n_fail++;
      $display("FAIL b2b_ack got irq/ov/fe/pe/data=%b want %b", obs(4), expv(4));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
